move_seq: RTL and testbench
===========================

MOVE_SEQ -- requirements
Module: move_seq

Interface
REQ-001 The block SHALL have parameter N_DST, default 5, meaning number of writable registers (R0..R3, P0).
REQ-002 The block SHALL have parameter N_SRC, default 6, meaning number of readable sources (N_DST writables plus read-only ports such as P1); N_SRC >= N_DST required.
REQ-003 The block SHALL have parameter IDX_W, default 6, meaning width of the register index fields.
REQ-004 clk  input  1  sole clock, all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a transfer; sampled only in IDLE.
REQ-007 mode  input  1  0 = MOVE (Ri <- Rj), 1 = SWAP (Ri <-> Rj via temp register).
REQ-008 ri  input  IDX_W  destination index.
REQ-009 rj  input  IDX_W  source index.
REQ-010 bus_ready  input  1  datapath accepts the current transfer step this cycle.
REQ-011 wr_en  output  N_DST  one-hot register write enables.
REQ-012 rd_en  output  N_SRC  one-hot source read enables.
REQ-013 tmp_wr  output  1  write enable for the internal-bus temp register.
REQ-014 tmp_rd  output  1  read enable for the temp register.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  one-cycle illegal-operand pulse, coincident with done.

Function
REQ-018 States SHALL be IDLE, XFER1, XFER2, XFER3, DONE, ERR; outputs SHALL be decoded from the registered state and latched operands only.
REQ-019 In IDLE with start=1, ri, rj, and mode SHALL be latched; later changes on ri, rj, and mode SHALL have no effect until the next IDLE.
REQ-020 Operand validity: MOVE requires ri < N_DST and rj < N_SRC; SWAP requires ri < N_DST and rj < N_DST.
REQ-021 IDLE + start + invalid operands -> ERR; ERR SHALL assert done=1, err=1, no enables, then go to IDLE.
REQ-022 IDLE + start + valid operands -> XFER1.
REQ-023 MOVE in XFER1: wr_en[ri]=1, rd_en[rj]=1; on bus_ready=1 -> DONE.
REQ-024 SWAP in XFER1: tmp_wr=1, rd_en[rj]=1; on bus_ready=1 -> XFER2.
REQ-025 SWAP in XFER2: wr_en[rj]=1, rd_en[ri]=1; on bus_ready=1 -> XFER3.
REQ-026 SWAP in XFER3: wr_en[ri]=1, tmp_rd=1; on bus_ready=1 -> DONE.
REQ-027 In any XFER state with bus_ready=0, the state and all enables SHALL hold unchanged (stall, no limit).
REQ-028 DONE SHALL assert done=1 for exactly one cycle with all enables 0, then go to IDLE.
REQ-029 At most one bit of wr_en and at most one bit of rd_en SHALL be high in any cycle; all enables SHALL be 0 in IDLE, DONE, and ERR.
REQ-030 start while busy=1, including in DONE and ERR, SHALL be ignored and not queued.
REQ-031 ri == rj SHALL be legal and execute the full step sequence for the mode.
REQ-032 Latency with bus_ready tied high: MOVE start edge -> done 2 cycles later; SWAP -> 4 cycles later; back-to-back start accepted the cycle after done.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE and clear latched operands, from any state including mid-XFER.
REQ-034 After reset, wr_en, rd_en, tmp_wr, tmp_rd, busy, done, and err SHALL all be 0.
REQ-035 reset SHALL take priority over start and bus_ready.

Verification
REQ-036 MOVE ri=2, rj=5, bus_ready=1 -> one cycle wr_en=00100, rd_en=100000; next cycle done=1, err=0; busy high 2 cycles.
REQ-037 SWAP ri=1, rj=3, bus_ready=1 -> steps {tmp_wr, rd_en[3]}, {wr_en[3], rd_en[1]}, {wr_en[1], tmp_rd}; then done pulse.
REQ-038 MOVE ri=0, rj=4, bus_ready low 3 cycles then high -> enables held 4 cycles; done on the following cycle.
REQ-039 MOVE ri=5 (>= N_DST), and separately SWAP rj=5 -> next cycle done=1, err=1, no enables ever asserted.
REQ-040 SWAP started, reset pulsed in XFER2 -> next cycle all outputs 0, busy=0, no done.
REQ-041 start held high continuously with ri and rj changing every cycle -> each operation uses the operands latched in IDLE; a new operation starts only on the cycle after each done.

Source files
------------

// File: rtl/move_seq.sv
// move_seq: sequencer that moves or swaps register contents over a shared internal bus.
//
// MOVE (mode=0) copies Rj into Ri in one bus step.
// SWAP (mode=1) exchanges Ri and Rj in three bus steps, using the bus temp register.
// Each bus step holds its enables until the datapath accepts it with bus_ready.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous active-high reset
//   start      : transfer request, sampled only while idle
//   mode       : 0 = MOVE, 1 = SWAP
//   ri, rj     : destination and source register indices
//   bus_ready  : datapath accepts the current bus step this cycle
//   wr_en      : one-hot register write enables (N_DST bits)
//   rd_en      : one-hot source read enables (N_SRC bits)
//   tmp_wr     : temp register write enable
//   tmp_rd     : temp register read enable
//   busy       : high in every state except idle
//   done       : one-cycle completion pulse
//   err        : one-cycle illegal-operand pulse, always coincident with done
module move_seq #(
  parameter int unsigned N_DST = 5,
  parameter int unsigned N_SRC = 6,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [IDX_W-1:0] ri,
  input  logic [IDX_W-1:0] rj,
  input  logic             bus_ready,
  output logic [N_DST-1:0] wr_en,
  output logic [N_SRC-1:0] rd_en,
  output logic             tmp_wr,
  output logic             tmp_rd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StXfer1 = 3'd1;
  localparam logic [2:0] StXfer2 = 3'd2;
  localparam logic [2:0] StXfer3 = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] ri_q, ri_d;
  logic [IDX_W-1:0] rj_q, rj_d;

  logic             ops_valid;
  logic             wr_act, rd_act;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // SWAP writes both operands back, so both must name writable registers;
  // MOVE only reads rj, so any readable source is allowed.
  always_comb begin
    ops_valid = (32'(ri) < N_DST) &&
                (mode ? (32'(rj) < N_DST) : (32'(rj) < N_SRC));
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ri_d    = ri_q;
    rj_d    = rj_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          ri_d    = ri;
          rj_d    = rj;
          state_d = ops_valid ? StXfer1 : StErr;
        end
      end
      StXfer1: if (bus_ready) state_d = mode_q ? StXfer2 : StDone;
      StXfer2: if (bus_ready) state_d = StXfer3;
      StXfer3: if (bus_ready) state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      ri_q    <= '0;
      rj_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ri_q    <= ri_d;
      rj_q    <= rj_d;
    end
  end

  // Step decode: pick at most one write index and one read index per state.
  always_comb begin
    wr_act = 1'b0;
    rd_act = 1'b0;
    wr_idx = '0;
    rd_idx = '0;
    tmp_wr = 1'b0;
    tmp_rd = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (state_q)
      StXfer1: begin
        // Both modes read Rj first; MOVE lands it in Ri, SWAP parks it in temp.
        rd_act = 1'b1;
        rd_idx = rj_q;
        if (mode_q) begin
          tmp_wr = 1'b1;
        end else begin
          wr_act = 1'b1;
          wr_idx = ri_q;
        end
      end
      StXfer2: begin
        wr_act = 1'b1;
        wr_idx = rj_q;
        rd_act = 1'b1;
        rd_idx = ri_q;
      end
      StXfer3: begin
        wr_act = 1'b1;
        wr_idx = ri_q;
        tmp_rd = 1'b1;
      end
      StDone: done = 1'b1;
      StErr: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < N_DST; k++) begin
      wr_en[k] = wr_act && (32'(wr_idx) == k);
    end
    for (int unsigned k = 0; k < N_SRC; k++) begin
      rd_en[k] = rd_act && (32'(rd_idx) == k);
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_move_seq.sv
// Bench for move_seq: a queue-of-steps model predicts every output each cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_move_seq;

  localparam int unsigned N_DST = 5;
  localparam int unsigned N_SRC = 6;
  localparam int unsigned IDX_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [IDX_W-1:0] ri = '0;
  logic [IDX_W-1:0] rj = '0;
  logic             bus_ready = 1'b0;
  logic [N_DST-1:0] wr_en;
  logic [N_SRC-1:0] rd_en;
  logic             tmp_wr, tmp_rd, busy, done, err;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  move_seq #(.N_DST(N_DST), .N_SRC(N_SRC), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ri(ri), .rj(rj),
    .bus_ready(bus_ready), .wr_en(wr_en), .rd_en(rd_en), .tmp_wr(tmp_wr),
    .tmp_rd(tmp_rd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // One entry per visible cycle of an operation; 'stall' entries wait for bus_ready.
  typedef struct packed {
    logic [N_DST-1:0] wr;
    logic [N_SRC-1:0] rd;
    logic             tw;
    logic             tr;
    logic             dn;
    logic             er;
    logic             stall;
  } step_t;

  step_t q[$];

  function automatic step_t mk(int w, int r, bit tw, bit tr, bit dn, bit er, bit stall);
    step_t s;
    s = '0;
    if (w >= 0) s.wr[w] = 1'b1;
    if (r >= 0) s.rd[r] = 1'b1;
    s.tw = tw;
    s.tr = tr;
    s.dn = dn;
    s.er = er;
    s.stall = stall;
    return s;
  endfunction

  // Model: empty queue means idle; a start in idle enqueues the whole operation.
  always @(posedge clk) begin
    int a, b;
    bit ok;
    a = int'(ri);
    b = int'(rj);
    if (reset) begin
      q.delete();
    end else if (q.size() != 0) begin
      if (!(q[0].stall && !bus_ready)) void'(q.pop_front());
    end else if (start) begin
      ok = (a < N_DST) && (mode ? (b < N_DST) : (b < N_SRC));
      if (!ok) begin
        q.push_back(mk(-1, -1, 0, 0, 1, 1, 0));
      end else if (!mode) begin
        q.push_back(mk(a, b, 0, 0, 0, 0, 1));
        q.push_back(mk(-1, -1, 0, 0, 1, 0, 0));
      end else begin
        q.push_back(mk(-1, b, 1, 0, 0, 0, 1));
        q.push_back(mk(b, a, 0, 0, 0, 0, 1));
        q.push_back(mk(a, -1, 0, 1, 0, 0, 1));
        q.push_back(mk(-1, -1, 0, 0, 1, 0, 0));
      end
    end
  end

  // Compare process: every cycle after reset, all outputs against the model.
  always @(negedge clk) begin
    step_t e;
    logic [N_DST+N_SRC+4:0] act, exp_v;
    if (chk_on) begin
      e = (q.size() != 0) ? q[0] : '0;
      act   = {wr_en, rd_en, tmp_wr, tmp_rd, done, err, busy};
      exp_v = {e.wr, e.rd, e.tw, e.tr, e.dn, e.er, (q.size() != 0)};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t got wr=%b rd=%b tw=%b tr=%b dn=%b er=%b bsy=%b exp %b",
                 $time, wr_en, rd_en, tmp_wr, tmp_rd, done, err, busy, exp_v);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  task automatic go(input bit m, input int a, input int b);
    start = 1'b1;
    mode = m;
    ri = IDX_W'(a);
    rj = IDX_W'(b);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    lit("rst_wr", 32'(wr_en), 0);
    lit("rst_rd", 32'(rd_en), 0);
    lit("rst_flags", 32'({tmp_wr, tmp_rd, busy, done, err}), 0);

    // MOVE R2 <- P1
    bus_ready = 1'b1;
    go(0, 2, 5);
    @(negedge clk);
    start = 1'b0;
    lit("mv_wr", 32'(wr_en), 32'b00100);
    lit("mv_rd", 32'(rd_en), 32'b100000);
    lit("mv_busy1", 32'(busy), 1);
    @(negedge clk);
    lit("mv_done", 32'({done, err, busy}), 32'b101);
    lit("mv_model_len", q.size(), 1);
    @(negedge clk);
    lit("mv_idle", 32'({busy, done}), 0);

    // SWAP R1 <-> R3
    go(1, 1, 3);
    @(negedge clk);
    start = 1'b0;
    lit("sw1", 32'({wr_en, rd_en, tmp_wr, tmp_rd}), 32'({5'b00000, 6'b001000, 2'b10}));
    @(negedge clk);
    lit("sw2", 32'({wr_en, rd_en, tmp_wr, tmp_rd}), 32'({5'b01000, 6'b000010, 2'b00}));
    @(negedge clk);
    lit("sw3", 32'({wr_en, rd_en, tmp_wr, tmp_rd}), 32'({5'b00010, 6'b000000, 2'b01}));
    @(negedge clk);
    lit("sw_done", 32'({done, err}), 32'b10);
    @(negedge clk);

    // MOVE R0 <- R4 with three stalled cycles
    bus_ready = 1'b0;
    go(0, 0, 4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lit("stall_en", 32'({wr_en, rd_en}), 32'({5'b00001, 6'b010000}));
      if (i == 3) bus_ready = 1'b1;
      @(negedge clk);
    end
    lit("stall_done", 32'({done, busy}), 32'b11);
    @(negedge clk);

    // Illegal operands
    go(0, 5, 0);
    @(negedge clk);
    start = 1'b0;
    lit("bad_mv", 32'({done, err, wr_en, rd_en}), 32'({2'b11, 11'd0}));
    @(negedge clk);
    go(1, 0, 5);
    @(negedge clk);
    start = 1'b0;
    lit("bad_sw", 32'({done, err, wr_en, rd_en}), 32'({2'b11, 11'd0}));
    @(negedge clk);

    // Reset while in the second SWAP step
    go(1, 2, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    lit("rs_in_x2", 32'(wr_en), 32'b00001);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lit("rs_outs", 32'({wr_en, rd_en, tmp_wr, tmp_rd, busy, done, err}), 0);
    @(negedge clk);
    lit("rs_nodone", 32'({busy, done}), 0);

    // Random: start mostly held, operands churning, bus_ready and reset random
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 9) < 8);
      mode = $urandom_range(0, 1) == 1;
      ri = IDX_W'($urandom_range(0, 7));
      rj = IDX_W'($urandom_range(0, 7));
      bus_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
